// File: rtl/ped_signal.sv
// rtl/ped_signal.sv - pedestrian WALK/DON'T WALK controller slaved to vehicle red_light
// Grants walk for a full vehicle red phase only and aborts with a fault pulse if red drops early.
module ped_signal #(
   parameter int WALK_TICKS  = 8,
   parameter int CLEAR_TICKS = 6,
   parameter int DEB_CYCLES  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       red_light,
   input  logic       btn,
   output logic       walk,
   output logic       dont_walk,
   output logic [3:0] countdown,
   output logic       req_pending,
   output logic       fault
);

   typedef enum logic [1:0] {ST_STOP, ST_WAIT, ST_WALK, ST_CLEAR} state_t;

   localparam logic [3:0] DEB_MAX    = 4'(DEB_CYCLES);
   localparam logic [3:0] WALK_LOAD  = 4'(WALK_TICKS - 1);
   localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_TICKS - 1);

   state_t     state, state_nx;
   logic       sync1, sync2;
   logic [3:0] deb_cnt;
   logic       press;
   logic       red_q;
   logic       red_rise;
   logic [3:0] cnt, cnt_nx;
   logic       flash, flash_nx;
   logic       abort;

   // Debounce saturates at DEB_MAX so a held button yields exactly one press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb_cnt <= 4'd0;
         press   <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (!sync2)
            deb_cnt <= 4'd0;
         else if (deb_cnt != DEB_MAX)
            deb_cnt <= deb_cnt + 4'd1;
         press <= sync2 && (deb_cnt == DEB_MAX - 4'd1);
      end
   end

   assign red_rise = red_light & ~red_q;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      flash_nx = flash;
      abort    = 1'b0;
      case (state)
         ST_STOP: begin
            if (press)
               state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (red_rise) begin
               state_nx = ST_WALK;
               cnt_nx   = WALK_LOAD;
            end
         end
         ST_WALK: begin
            if (!red_light) begin
               abort    = 1'b1;
               state_nx = ST_STOP;
               cnt_nx   = 4'd0;
            end else if (tick) begin
               if (cnt == 4'd0) begin
                  state_nx = ST_CLEAR;
                  cnt_nx   = CLEAR_LOAD;
                  flash_nx = 1'b1;
               end else begin
                  cnt_nx = cnt - 4'd1;
               end
            end
         end
         ST_CLEAR: begin
            if (!red_light) begin
               abort    = 1'b1;
               state_nx = ST_STOP;
               cnt_nx   = 4'd0;
               flash_nx = 1'b1;
            end else if (tick) begin
               if (cnt == 4'd0) begin
                  state_nx = ST_STOP;
                  flash_nx = 1'b1;
               end else begin
                  cnt_nx   = cnt - 4'd1;
                  flash_nx = ~flash;
               end
            end
         end
         default: begin
            state_nx = ST_STOP;
            cnt_nx   = 4'd0;
            flash_nx = 1'b1;
         end
      endcase
   end

   // Lamp outputs are decoded from next-state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_STOP;
         cnt         <= 4'd0;
         flash       <= 1'b1;
         red_q       <= 1'b1;
         walk        <= 1'b0;
         dont_walk   <= 1'b1;
         countdown   <= 4'd0;
         req_pending <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         flash       <= flash_nx;
         red_q       <= red_light;
         walk        <= (state_nx == ST_WALK);
         dont_walk   <= (state_nx == ST_CLEAR) ? flash_nx : (state_nx != ST_WALK);
         countdown   <= (state_nx == ST_CLEAR) ? cnt_nx : 4'd0;
         req_pending <= (state_nx == ST_WAIT);
         fault       <= abort;
      end
   end

endmodule
